// File: rtl/prime_checker_seq_if.sv
// Request/result handshake for the sequential trial-division prime checker.
interface prime_checker_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic             is_prime;

  modport master (output start, n, input busy, done, is_prime);
  modport slave  (input start, n, output busy, done, is_prime);
endinterface

// File: rtl/prime_checker_seq.sv
// Sequential prime checker: one trial divisor per clock, done pulse plus held is_prime.
// Optional macro PRIME_ODD_SKIP_EN: after d=2, only odd divisors are tried.
module prime_checker_seq #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  prime_checker_seq_if.slave bus
);

  typedef enum logic {IDLE, CHECK} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   n_q;
  logic [WIDTH:0]     div_q;
  logic [WIDTH:0]     div_d;
  logic [2*WIDTH+1:0] sq;
  logic [2*WIDTH+1:0] n_ext;
  logic [WIDTH:0]     rem;
  logic               busy_q;
  logic               done_q;
  logic               prime_q;
  logic               n_small;
  logic               sq_above;
  logic               finish;

  // Square is carried at double width so the compare never wraps.
  assign sq       = {{(WIDTH+1){1'b0}}, div_q} * {{(WIDTH+1){1'b0}}, div_q};
  assign n_ext    = {{(WIDTH+2){1'b0}}, n_q};
  assign rem      = {1'b0, n_q} % div_q;
  assign n_small  = (n_q < WIDTH'(2));
  assign sq_above = (sq > n_ext);
  assign finish   = n_small || sq_above || (rem == '0);

`ifdef PRIME_ODD_SKIP_EN
  assign div_d = (div_q == (WIDTH+1)'(2)) ? (WIDTH+1)'(3) : div_q + (WIDTH+1)'(2);
`else
  assign div_d = div_q + (WIDTH+1)'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prime_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            n_q     <= bus.n;
            div_q   <= (WIDTH+1)'(2);
            busy_q  <= 1'b1;
            prime_q <= 1'b0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (finish) begin
            // Priority collapses to: prime iff n >= 2 and no divisor up to sqrt(n) hit.
            prime_q <= !n_small && sq_above;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            div_q <= div_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.is_prime = prime_q;

endmodule

// File: tb/tb_prime_checker_seq.sv
// Scoreboard bench for prime_checker_seq: 8-bit and 4-bit instances, directed vectors.
module tb_prime_checker_seq;

`ifdef PRIME_ODD_SKIP_EN
  localparam int L251 = 9;
`else
  localparam int L251 = 15;
`endif

  typedef struct {
    bit exp;
    int lat;
    int start_cyc;
    int n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q8[$];
  exp_t q4[$];

  prime_checker_seq_if #(.WIDTH(8)) bus8 ();
  prime_checker_seq_if #(.WIDTH(4)) bus4 ();

  prime_checker_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  prime_checker_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int primes[54] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61,
                     67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131, 137,
                     139, 149, 151, 157, 163, 167, 173, 179, 181, 191, 193, 197, 199, 211,
                     223, 227, 229, 233, 239, 241, 251};

  function automatic bit is_p(input int v);
    foreach (primes[i]) if (primes[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int hand_lat(input int v);
    case (v)
      0, 1, 2, 3, 4: return 1;
      7, 9:          return 2;
      13:            return 3;
      251:           return L251;
      default:       return -1;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus8.done) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check($sformatf("w8_is_prime_n%0d", e.n), int'(bus8.is_prime), int'(e.exp));
        check($sformatf("w8_busy_at_done_n%0d", e.n), int'(bus8.busy), 0);
        if (e.lat > 0) check($sformatf("w8_latency_n%0d", e.n), cyc - e.start_cyc, e.lat);
      end
    end
    if (!rst && bus4.done) begin
      if (q4.size() == 0) begin
        check("w4_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check($sformatf("w4_is_prime_n%0d", e.n), int'(bus4.is_prime), int'(e.exp));
        check($sformatf("w4_busy_at_done_n%0d", e.n), int'(bus4.busy), 0);
      end
    end
  end

  // Called at a negedge; start is seen by the following rising edge.
  task automatic issue8(input int v, input bit push);
    exp_t e;
    bus8.n     = 8'(v);
    bus8.start = 1'b1;
    if (push) begin
      e.exp = is_p(v);
      e.lat = hand_lat(v);
      e.start_cyc = cyc + 1;
      e.n = v;
      q8.push_back(e);
    end
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic wait_done8(input string name);
    int k = 0;
    while (!bus8.done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    bus8.start = 1'b0;
    bus8.n     = '0;
    bus4.start = 1'b0;
    bus4.n     = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(bus8.busy), 0);
    check("reset_done", int'(bus8.done), 0);
    check("reset_is_prime", int'(bus8.is_prime), 0);
    rst = 1'b0;
    @(negedge clk);

    issue8(7, 1'b1);   wait_done8("lat7");   @(negedge clk);
    issue8(4, 1'b1);   wait_done8("lat4");   @(negedge clk);
    issue8(251, 1'b1); wait_done8("lat251"); @(negedge clk);

    // Start while busy: the n=4 request lands mid-check and must vanish.
    issue8(251, 1'b1);
    @(negedge clk);
    bus8.n = 8'd4;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8("busy_ignore");
    repeat (20) @(negedge clk);

    // Reset mid-check: no done may follow the aborted request.
    issue8(251, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(bus8.busy), 0);
    check("abort_done", int'(bus8.done), 0);
    check("abort_is_prime", int'(bus8.is_prime), 0);
    repeat (20) @(negedge clk);
    issue8(13, 1'b1); wait_done8("after_abort"); @(negedge clk);

    // Back-to-back: second start issued in the first check's done cycle.
    issue8(7, 1'b1);
    wait_done8("b2b_first");
    issue8(9, 1'b1);
    check("b2b_busy_after_accept", int'(bus8.busy), 1);
    check("b2b_is_prime_cleared", int'(bus8.is_prime), 0);
    wait_done8("b2b_second");
    @(negedge clk);

    for (int v = 0; v < 256; v++) begin
      issue8(v, 1'b1);
      wait_done8("sweep8");
      @(negedge clk);
    end

    for (int v = 0; v < 16; v++) begin
      exp_t e;
      int k;
      bus4.n = 4'(v);
      bus4.start = 1'b1;
      e.exp = is_p(v);
      e.lat = -1;
      e.start_cyc = cyc + 1;
      e.n = v;
      q4.push_back(e);
      @(negedge clk);
      bus4.start = 1'b0;
      k = 0;
      while (!bus4.done && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (k >= 50) check("sweep4_timeout", 1, 0);
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("w8_pending_expectations", q8.size(), 0);
    check("w4_pending_expectations", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
